// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_pkg
// Description : Shared types and helpers for the set-associative cache.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

  // Controller states
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WRITE_BACK = 3'd1,
    ST_ALLOCATE   = 3'd2,
    ST_FLUSH_SCAN = 3'd3,
    ST_FLUSH_WB   = 3'd4
  } state_t;

  // Index width that never collapses to zero bits (WAYS=1 still needs a 1-bit pointer)
  function automatic int safe_clog2(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_way_ram.sv
`default_nettype none
// ============================================================================
// Module      : cache_way_ram
// Description : Data array for one cache way. Asynchronous line read,
//               synchronous full-line fill or byte-enabled word write.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_way_ram #(
  parameter int SETS      = 64,
  parameter int IDX_W     = 6,
  parameter int WORD_W    = 2,
  parameter int LINE_BITS = 128
) (
  input  logic                 clk,
  input  logic                 line_wr_en,
  input  logic                 word_wr_en,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic [WORD_W-1:0]    wr_word,
  input  logic [3:0]           wr_be,
  input  logic [31:0]          wr_data,
  input  logic [LINE_BITS-1:0] wr_line,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic [LINE_BITS-1:0] rd_line
);

  logic [LINE_BITS-1:0] r_mem [SETS];

  // Fill replaces the whole line; a CPU write merges only the enabled bytes
  always_ff @(posedge clk) begin
    if (line_wr_en) begin
      r_mem[wr_idx] <= wr_line;
    end else if (word_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) r_mem[wr_idx][{wr_word, b[1:0], 3'b000} +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  assign rd_line = r_mem[rd_idx];

endmodule
`default_nettype wire

// File: rtl/assoc_cache.sv
`default_nettype none
// ============================================================================
// Module      : assoc_cache
// Description : N-way set-associative write-back / write-allocate cache with
//               round-robin replacement and whole-cache flush.
// Revision    : 1.0 - initial release
// ============================================================================
module assoc_cache
  import cache_pkg::*;
#(
  parameter int ADDR_W     = 17,
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 64,
  parameter int WAYS       = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_W-1:0]         cpu_req_addr,
  input  logic                      cpu_req_valid,
  input  logic                      cpu_req_wr,
  input  logic [3:0]                cpu_req_be,
  input  logic [31:0]               cpu_wr_data,
  output logic [31:0]               cpu_rd_data,
  output logic                      cpu_req_ready,
  input  logic                      flush_req,
  output logic                      flush_done,
  output logic [ADDR_W-1:0]         mem_req_addr,
  output logic                      mem_req_valid,
  output logic                      mem_req_wr,
  output logic [32*LINE_WORDS-1:0]  mem_wr_data,
  input  logic [32*LINE_WORDS-1:0]  mem_rd_data,
  input  logic                      mem_req_ready
);

  localparam int LINE_BITS = 32 * LINE_WORDS;
  localparam int OFF_W     = $clog2(LINE_WORDS * 4);
  localparam int IDX_W     = $clog2(SETS);
  localparam int TAG_W     = ADDR_W - IDX_W - OFF_W;
  localparam int WORD_W    = OFF_W - 2;
  localparam int WAY_W     = safe_clog2(WAYS);

  state_t               r_state;
  logic [WAY_W-1:0]     r_victim_way;
  logic [TAG_W-1:0]     r_victim_tag;
  logic [IDX_W-1:0]     r_fl_set;
  logic [WAY_W-1:0]     r_fl_way;
  logic [TAG_W-1:0]     r_tag   [WAYS][SETS];
  logic [SETS-1:0]      r_valid [WAYS];
  logic [SETS-1:0]      r_dirty [WAYS];
  logic [WAY_W-1:0]     r_rr    [SETS];

  logic [TAG_W-1:0]     w_tag;
  logic [IDX_W-1:0]     w_idx;
  logic [WORD_W-1:0]    w_word;
  logic                 w_hit;
  logic [WAY_W-1:0]     w_hit_way;
  logic                 w_inv_found;
  logic [WAY_W-1:0]     w_inv_way;
  logic [WAY_W-1:0]     w_victim;
  logic                 w_victim_dirty;
  logic [WAY_W-1:0]     w_rr_next;
  logic                 w_hit_wr;
  logic                 w_fill_fire;
  logic                 w_flushing;
  logic                 w_fl_dirty;
  logic                 w_fl_last;
  logic [IDX_W-1:0]     w_rd_idx;
  logic [WAY_W-1:0]     w_rd_way;
  logic [LINE_BITS-1:0] w_lines [WAYS];
  logic [LINE_BITS-1:0] w_sel_line;
  logic                 w_unused;

  assign w_tag    = cpu_req_addr[ADDR_W-1 -: TAG_W];
  assign w_idx    = cpu_req_addr[OFF_W +: IDX_W];
  assign w_word   = cpu_req_addr[2 +: WORD_W];
  assign w_unused = ^cpu_req_addr[1:0];

  // Tag lookup and victim choice: lowest invalid way, else round-robin pointer
  always_comb begin
    w_hit       = 1'b0;
    w_hit_way   = '0;
    w_inv_found = 1'b0;
    w_inv_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w][w_idx] && (r_tag[w][w_idx] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!r_valid[w][w_idx]) begin
        w_inv_found = 1'b1;
        w_inv_way   = WAY_W'(w);
      end
    end
    w_victim = w_inv_found ? w_inv_way : r_rr[w_idx];
  end

  assign w_victim_dirty = r_valid[w_victim][w_idx] && r_dirty[w_victim][w_idx];
  assign w_rr_next      = (r_rr[w_idx] == WAY_W'(WAYS - 1)) ? '0 : r_rr[w_idx] + 1'b1;

  assign cpu_req_ready = (r_state == ST_IDLE) && !flush_req && cpu_req_valid && w_hit;
  assign w_hit_wr      = cpu_req_ready && cpu_req_wr;
  assign w_fill_fire   = (r_state == ST_ALLOCATE) && mem_req_ready;

  assign w_flushing = (r_state == ST_FLUSH_SCAN) || (r_state == ST_FLUSH_WB);
  assign w_fl_dirty = r_valid[r_fl_way][r_fl_set] && r_dirty[r_fl_way][r_fl_set];
  assign w_fl_last  = (r_fl_set == IDX_W'(SETS - 1)) && (r_fl_way == WAY_W'(WAYS - 1));
  assign flush_done = (r_state == ST_FLUSH_SCAN) && !w_fl_dirty && w_fl_last;

  // Data-array read port follows the flush walker, the hit way or the victim
  always_comb begin
    w_rd_idx = w_flushing ? r_fl_set : w_idx;
    case (r_state)
      ST_FLUSH_SCAN, ST_FLUSH_WB: w_rd_way = r_fl_way;
      ST_IDLE:                    w_rd_way = w_hit_way;
      default:                    w_rd_way = r_victim_way;
    endcase
  end

  assign w_sel_line  = w_lines[w_rd_way];
  assign cpu_rd_data = (cpu_req_ready && !cpu_req_wr) ? w_sel_line[{w_word, 5'b00000} +: 32] : 32'd0;

  generate
    for (genvar g = 0; g < WAYS; g++) begin : g_way
      cache_way_ram #(
        .SETS      (SETS),
        .IDX_W     (IDX_W),
        .WORD_W    (WORD_W),
        .LINE_BITS (LINE_BITS)
      ) u_ram (
        .clk        (clk),
        .line_wr_en (w_fill_fire && (r_victim_way == WAY_W'(g))),
        .word_wr_en (w_hit_wr && (w_hit_way == WAY_W'(g))),
        .wr_idx     (w_idx),
        .wr_word    (w_word),
        .wr_be      (cpu_req_be),
        .wr_data    (cpu_wr_data),
        .wr_line    (mem_rd_data),
        .rd_idx     (w_rd_idx),
        .rd_line    (w_lines[g])
      );
    end
  endgenerate

  // Memory request is purely a function of state, so reset removes it at once
  always_comb begin
    mem_req_valid = 1'b0;
    mem_req_wr    = 1'b0;
    mem_req_addr  = '0;
    mem_wr_data   = '0;
    case (r_state)
      ST_WRITE_BACK: begin
        mem_req_valid = 1'b1;
        mem_req_wr    = 1'b1;
        mem_req_addr  = {r_victim_tag, w_idx, {OFF_W{1'b0}}};
        mem_wr_data   = w_sel_line;
      end
      ST_ALLOCATE: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {w_tag, w_idx, {OFF_W{1'b0}}};
      end
      ST_FLUSH_WB: begin
        mem_req_valid = 1'b1;
        mem_req_wr    = 1'b1;
        mem_req_addr  = {r_tag[r_fl_way][r_fl_set], r_fl_set, {OFF_W{1'b0}}};
        mem_wr_data   = w_sel_line;
      end
      default: ;
    endcase
  end

  // Tags carry no reset; they are only meaningful under a valid bit
  always_ff @(posedge clk) begin
    if (w_fill_fire) r_tag[r_victim_way][w_idx] <= w_tag;
  end

  // Controller, valid/dirty bookkeeping, replacement pointers and flush walker
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_victim_way <= '0;
      r_victim_tag <= '0;
      r_fl_set     <= '0;
      r_fl_way     <= '0;
      for (int w = 0; w < WAYS; w++) begin
        r_valid[w] <= '0;
        r_dirty[w] <= '0;
      end
      for (int s = 0; s < SETS; s++) r_rr[s] <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (flush_req) begin
            r_state  <= ST_FLUSH_SCAN;
            r_fl_set <= '0;
            r_fl_way <= '0;
          end else if (cpu_req_valid) begin
            if (w_hit) begin
              if (cpu_req_wr) r_dirty[w_hit_way][w_idx] <= 1'b1;
            end else begin
              r_victim_way <= w_victim;
              r_victim_tag <= r_tag[w_victim][w_idx];
              r_state      <= w_victim_dirty ? ST_WRITE_BACK : ST_ALLOCATE;
            end
          end
        end
        ST_WRITE_BACK: begin
          if (mem_req_ready) r_state <= ST_ALLOCATE;
        end
        ST_ALLOCATE: begin
          if (mem_req_ready) begin
            r_valid[r_victim_way][w_idx] <= 1'b1;
            r_dirty[r_victim_way][w_idx] <= 1'b0;
            r_rr[w_idx]                  <= w_rr_next;
            r_state                      <= ST_IDLE;
          end
        end
        ST_FLUSH_SCAN: begin
          if (w_fl_dirty) begin
            r_state <= ST_FLUSH_WB;
          end else begin
            r_valid[r_fl_way][r_fl_set] <= 1'b0;
            if (w_fl_last) begin
              r_state  <= ST_IDLE;
              r_fl_set <= '0;
              r_fl_way <= '0;
              for (int s = 0; s < SETS; s++) r_rr[s] <= '0;
            end else if (r_fl_way == WAY_W'(WAYS - 1)) begin
              r_fl_way <= '0;
              r_fl_set <= r_fl_set + 1'b1;
            end else begin
              r_fl_way <= r_fl_way + 1'b1;
            end
          end
        end
        ST_FLUSH_WB: begin
          // Entry is cleared here; the scan revisits it and then moves on
          if (mem_req_ready) begin
            r_valid[r_fl_way][r_fl_set] <= 1'b0;
            r_dirty[r_fl_way][r_fl_set] <= 1'b0;
            r_state                     <= ST_FLUSH_SCAN;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_assoc_cache.sv
`default_nettype none
// ============================================================================
// Module      : tb_assoc_cache
// Description : Self-checking bench for assoc_cache against a behavioural
//               cache/memory model with randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_assoc_cache;

  localparam int ADDR_W     = 17;
  localparam int LINE_WORDS = 4;
  localparam int SETS       = 64;
  localparam int WAYS       = 2;
  localparam int LINE_BITS  = 32 * LINE_WORDS;
  localparam int TAG_SH     = $clog2(SETS) + $clog2(LINE_WORDS * 4);
  localparam int MEM_WORDS  = (1 << ADDR_W) / 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [ADDR_W-1:0]     cpu_req_addr = '0;
  logic                  cpu_req_valid = 1'b0;
  logic                  cpu_req_wr = 1'b0;
  logic [3:0]            cpu_req_be = '0;
  logic [31:0]           cpu_wr_data = '0;
  logic [31:0]           cpu_rd_data;
  logic                  cpu_req_ready;
  logic                  flush_req = 1'b0;
  logic                  flush_done;
  logic [ADDR_W-1:0]     mem_req_addr;
  logic                  mem_req_valid;
  logic                  mem_req_wr;
  logic [LINE_BITS-1:0]  mem_wr_data;
  logic [LINE_BITS-1:0]  mem_rd_data = '0;
  logic                  mem_req_ready = 1'b0;

  always #5 clk = ~clk;

  assoc_cache #(
    .ADDR_W(ADDR_W), .LINE_WORDS(LINE_WORDS), .SETS(SETS), .WAYS(WAYS)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req_addr(cpu_req_addr), .cpu_req_valid(cpu_req_valid), .cpu_req_wr(cpu_req_wr),
    .cpu_req_be(cpu_req_be), .cpu_wr_data(cpu_wr_data), .cpu_rd_data(cpu_rd_data),
    .cpu_req_ready(cpu_req_ready), .flush_req(flush_req), .flush_done(flush_done),
    .mem_req_addr(mem_req_addr), .mem_req_valid(mem_req_valid), .mem_req_wr(mem_req_wr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .mem_req_ready(mem_req_ready)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Golden CPU-visible memory and the backing store the bench serves lines from
  logic [31:0] gold [MEM_WORDS];
  logic [31:0] back [MEM_WORDS];

  // Cache model: per set/way presence, dirtiness and tag plus round-robin pointer
  bit m_v   [SETS][WAYS];
  bit m_d   [SETS][WAYS];
  int m_tag [SETS][WAYS];
  int m_rr  [SETS];

  int mem_delay = 0;
  int wait_cnt = 0;
  int exp_fill_addr = 0;
  int exp_wb_q [$];
  int fill_cnt = 0;
  int wb_cnt = 0;
  int done_cnt = 0;

  function automatic logic [LINE_BITS-1:0] gold_line(input int la);
    logic [LINE_BITS-1:0] l;
    for (int k = 0; k < LINE_WORDS; k++) l[k*32 +: 32] = gold[(la >> 2) + k];
    return l;
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < SETS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < WAYS; w++) begin
        m_v[s][w] = 1'b0;
        m_d[s][w] = 1'b0;
      end
    end
  endfunction

  // Memory responder: accepts after mem_delay waiting cycles, checks every request
  always @(negedge clk) begin
    if (rst) begin
      mem_req_ready = 1'b0;
      wait_cnt = 0;
    end else if (mem_req_valid) begin
      if (wait_cnt >= mem_delay) begin
        mem_req_ready = 1'b1;
        wait_cnt = 0;
        if (mem_req_wr) begin
          wb_cnt++;
          if (exp_wb_q.size() > 0) check_val("wb_addr", 160'(mem_req_addr), 160'(exp_wb_q.pop_front()));
          else check_val("wb_unexpected", 160'(mem_req_addr), 160'(1 << ADDR_W));
          check_val("wb_data", 160'(mem_wr_data), 160'(gold_line(int'(mem_req_addr))));
          for (int k = 0; k < LINE_WORDS; k++) back[(mem_req_addr >> 2) + k] = mem_wr_data[k*32 +: 32];
        end else begin
          fill_cnt++;
          check_val("fill_addr", 160'(mem_req_addr), 160'(exp_fill_addr));
          for (int k = 0; k < LINE_WORDS; k++) mem_rd_data[k*32 +: 32] = back[(mem_req_addr >> 2) + k];
        end
      end else begin
        mem_req_ready = 1'b0;
        wait_cnt++;
      end
    end else begin
      mem_req_ready = 1'b0;
    end
  end

  // A stalled memory request must not change until accepted
  logic                 p_stall = 1'b0;
  logic                 p_wr;
  logic [ADDR_W-1:0]    p_addr;
  logic [LINE_BITS-1:0] p_data;
  always @(negedge clk) begin
    #2;
    if (rst) begin
      p_stall = 1'b0;
    end else begin
      if (p_stall)
        check_val("mem_hold", 160'({mem_req_valid, mem_req_wr, mem_req_addr, mem_wr_data}),
                  160'({1'b1, p_wr, p_addr, p_data}));
      p_stall = mem_req_valid && !mem_req_ready;
      p_wr    = mem_req_wr;
      p_addr  = mem_req_addr;
      p_data  = mem_wr_data;
    end
  end

  always @(negedge clk) if (flush_done) done_cnt++;

  task automatic cpu_access(input int addr, input bit wr, input logic [3:0] be, input logic [31:0] data);
    int set, tag, way, cyc, exp_cyc;
    bit hit;
    set = (addr >> 4) % SETS;
    tag = addr >> TAG_SH;
    hit = 1'b0;
    way = 0;
    for (int w = 0; w < WAYS; w++)
      if (m_v[set][w] && m_tag[set][w] == tag) begin hit = 1'b1; way = w; end
    exp_cyc = 1;
    if (!hit) begin
      way = -1;
      for (int w = WAYS - 1; w >= 0; w--) if (!m_v[set][w]) way = w;
      if (way < 0) way = m_rr[set];
      exp_cyc = 2 + (mem_delay + 1);
      if (m_v[set][way] && m_d[set][way]) begin
        exp_wb_q.push_back((m_tag[set][way] << TAG_SH) | (set << 4));
        exp_cyc += mem_delay + 1;
      end
      m_v[set][way] = 1'b1;
      m_d[set][way] = 1'b0;
      m_tag[set][way] = tag;
      m_rr[set] = (m_rr[set] + 1) % WAYS;
      exp_fill_addr = addr & ~15;
    end
    @(negedge clk);
    cpu_req_addr  = ADDR_W'(addr);
    cpu_req_wr    = wr;
    cpu_req_be    = be;
    cpu_wr_data   = data;
    cpu_req_valid = 1'b1;
    cyc = 0;
    forever begin
      #1;
      cyc++;
      if (cpu_req_ready || cyc > 200) break;
      @(negedge clk);
    end
    check_val("latency", 160'(cyc), 160'(exp_cyc));
    if (cpu_req_ready) begin
      if (!wr) begin
        check_val("rd_data", 160'(cpu_rd_data), 160'(gold[addr >> 2]));
      end else begin
        for (int b = 0; b < 4; b++) if (be[b]) gold[addr >> 2][b*8 +: 8] = data[b*8 +: 8];
        m_d[set][way] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    cpu_req_valid = 1'b0;
  endtask

  task automatic do_flush();
    int nd, d0, w0, cyc;
    nd = 0;
    for (int s = 0; s < SETS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < WAYS; w++) begin
        if (m_v[s][w] && m_d[s][w]) begin
          exp_wb_q.push_back((m_tag[s][w] << TAG_SH) | (s << 4));
          nd++;
        end
        m_v[s][w] = 1'b0;
        m_d[s][w] = 1'b0;
      end
    end
    d0 = done_cnt;
    w0 = wb_cnt;
    @(negedge clk);
    flush_req = 1'b1;
    cyc = 0;
    forever begin
      #1;
      cyc++;
      if (flush_done || cyc > 5000) break;
      @(negedge clk);
    end
    flush_req = 1'b0;
    repeat (3) @(negedge clk);
    check_val("flush_wb_count", 160'(wb_cnt - w0), 160'(nd));
    check_val("flush_done_count", 160'(done_cnt - d0), 160'(1));
    check_val("flush_len", 160'(cyc >= SETS * WAYS), 160'(1));
    check_val("wb_queue_empty", 160'(exp_wb_q.size()), 160'(0));
  endtask

  initial begin
    int a, cyc, diff;
    for (int i = 0; i < MEM_WORDS; i++) begin
      gold[i] = (i * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
      back[i] = gold[i];
    end
    gold[16] = 32'h1111_1111; gold[17] = 32'h2222_2222;
    gold[18] = 32'h3333_3333; gold[19] = 32'h4444_4444;
    for (int i = 16; i < 20; i++) back[i] = gold[i];
    model_clear();

    // Reset state
    #1;
    check_val("rst_ready", 160'(cpu_req_ready), 160'(0));
    check_val("rst_mem_valid", 160'(mem_req_valid), 160'(0));
    check_val("rst_flush_done", 160'(flush_done), 160'(0));
    check_val("rst_mem_addr", 160'(mem_req_addr), 160'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Clean read miss, hit in the same line, byte-enabled write, readback
    mem_delay = 0;
    cpu_access(32'h00040, 1'b0, 4'h0, 32'h0);
    cpu_access(32'h0004C, 1'b0, 4'h0, 32'h0);
    cpu_access(32'h00044, 1'b1, 4'b0011, 32'hAAAA_BBBB);
    cpu_access(32'h00044, 1'b0, 4'h0, 32'h0);
    check_val("merged_word", 160'(gold[17]), 160'(32'h2222_BBBB));
    // Same-index conflicts: invalid way first, then dirty victim write-back
    cpu_access(32'h00440, 1'b0, 4'h0, 32'h0);
    cpu_access(32'h00840, 1'b0, 4'h0, 32'h0);
    check_val("wb_happened", 160'(back[17]), 160'(32'h2222_BBBB));
    // One dirty and one clean line, then flush; both must miss afterwards
    cpu_access(32'h00440, 1'b1, 4'b1111, 32'hDEAD_BEEF);
    do_flush();
    cpu_access(32'h00440, 1'b0, 4'h0, 32'h0);
    cpu_access(32'h00840, 1'b0, 4'h0, 32'h0);
    // Long memory stall
    mem_delay = 10;
    cpu_access(32'h01080, 1'b0, 4'h0, 32'h0);
    mem_delay = 0;

    // Reset in the middle of a fill
    mem_delay = 20;
    exp_fill_addr = 32'h00040;
    @(negedge clk);
    cpu_req_addr = ADDR_W'(32'h00040);
    cpu_req_wr = 1'b0;
    cpu_req_valid = 1'b1;
    cyc = 0;
    while (!mem_req_valid && cyc < 10) begin @(negedge clk); cyc++; end
    check_val("alloc_seen", 160'(mem_req_valid && !mem_req_wr), 160'(1));
    #3 rst = 1'b1;
    #1;
    check_val("rst_async_mem_valid", 160'(mem_req_valid), 160'(0));
    check_val("rst_async_ready", 160'(cpu_req_ready), 160'(0));
    cpu_req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear();
    mem_delay = 0;
    cpu_access(32'h00040, 1'b0, 4'h0, 32'h0);

    // Randomized traffic over a handful of conflicting lines
    for (int n = 0; n < 400; n++) begin
      mem_delay = $urandom_range(0, 3);
      if ($urandom_range(0, 49) == 0) do_flush();
      if ($urandom_range(0, 3) == 0) a = $urandom_range(0, SETS - 1);
      else a = $urandom_range(0, 3);
      a = ($urandom_range(0, 3) << TAG_SH) | (a << 4) | ($urandom_range(0, LINE_WORDS - 1) << 2);
      cpu_access(a, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
    end
    do_flush();

    diff = 0;
    for (int i = 0; i < MEM_WORDS; i++) if (back[i] !== gold[i]) diff++;
    check_val("final_memory_diff", 160'(diff), 160'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
